// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: FSM and owner encodings, default access
// length, and a helper to size the access countdown counter.
package sram_arbiter_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [0:0] OWN_IF  = 1'b0;
   localparam logic [0:0] OWN_MEM = 1'b1;

   // Pipeline hazard/stall logic is expected to agree with this default.
   localparam int DEF_ACCESS_CYCLES = 2;

   // Bits needed to hold ACCESS_CYCLES-1; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/sram_port_ctrl.sv
// Registered SRAM strobe generator. Driven from the arbiter's next-state values
// so the strobes change exactly on entry to and exit from BUSY, glitch-free.
module sram_port_ctrl
   import sram_arbiter_pkg::*;
#(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             busy_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             ce_n_o,
   output logic             oe_n_o,
   output logic             we_n_o,
   output logic             dout_en_o
);

   logic ce_n_q;
   logic oe_n_q;
   logic we_n_q;
   logic dout_en_q;

   // Strobe registers; we_n is released in the final BUSY cycle to give write data hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         dout_en_q <= 1'b0;
      end else begin
         ce_n_q    <= ~busy_i;
         oe_n_q    <= ~(busy_i & ~we_i);
         we_n_q    <= ~(busy_i & we_i & (cnt_i != {CNT_W{1'b0}}));
         dout_en_q <= busy_i & we_i;
      end
   end

   assign ce_n_o    = ce_n_q;
   assign oe_n_o    = oe_n_q;
   assign we_n_o    = we_n_q;
   assign dout_en_o = dout_en_q;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM between the IF stage (read-only) and the MEM stage (read/write).
// MEM wins arbitration in IDLE; each access then runs ACCESS_CYCLES BUSY cycles.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int                          ADDR_W        = 16,
   parameter int                          DATA_W        = 16,
   parameter int                          RAM_ADDR_W    = 18,
   parameter logic [RAM_ADDR_W-ADDR_W-1:0] RAM_BASE      = '0,
   parameter int                          ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   input  logic                  if_abort_i,
   output logic [DATA_W-1:0]     if_rdata_o,
   output logic                  if_done_o,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [DATA_W-1:0]     mem_wdata_i,
   output logic [DATA_W-1:0]     mem_rdata_o,
   output logic                  mem_done_o,
   output logic                  stall_o,
   output logic [RAM_ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0]     ram_dout_o,
   output logic                  ram_dout_en_o,
   input  logic [DATA_W-1:0]     ram_din_i,
   output logic                  ram_ce_n_o,
   output logic                  ram_oe_n_o,
   output logic                  ram_we_n_o
);

   localparam int               CNT_W    = cnt_width(ACCESS_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

   logic [0:0]            state_q, state_d;
   logic [0:0]            owner_q, owner_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]     ram_dout_q, ram_dout_d;

   logic last_s;
   logic abort_s;
   logic if_done_s;
   logic mem_done_s;

   assign last_s  = (state_q == ST_BUSY) && (cnt_q == {CNT_W{1'b0}});
   assign abort_s = (state_q == ST_BUSY) && (owner_q == OWN_IF) && if_abort_i;

   // Arbitration and access sequencing; request ports are only sampled in IDLE.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      ram_addr_d = ram_addr_q;
      ram_dout_d = ram_dout_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_req_i) begin
               state_d    = ST_BUSY;
               owner_d    = OWN_MEM;
               we_d       = mem_we_i;
               ram_addr_d = {RAM_BASE, mem_addr_i};
               ram_dout_d = mem_wdata_i;
               cnt_d      = CNT_LOAD;
            end else if (if_req_i && !if_abort_i) begin
               state_d    = ST_BUSY;
               owner_d    = OWN_IF;
               we_d       = 1'b0;
               ram_addr_d = {RAM_BASE, if_addr_i};
               cnt_d      = CNT_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A flushed fetch leaves immediately; no regrant straight from BUSY.
            if (abort_s || (cnt_q == {CNT_W{1'b0}})) begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // FSM state and latched access parameters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         cnt_q      <= {CNT_W{1'b0}};
         we_q       <= 1'b0;
         ram_addr_q <= {RAM_ADDR_W{1'b0}};
         ram_dout_q <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         ram_addr_q <= ram_addr_d;
         ram_dout_q <= ram_dout_d;
      end
   end

   sram_port_ctrl #(
      .CNT_W (CNT_W)
   ) u_port_ctrl (
      .clk       (clk),
      .rst       (rst),
      .busy_i    (state_d == ST_BUSY),
      .we_i      (we_d),
      .cnt_i     (cnt_d),
      .ce_n_o    (ram_ce_n_o),
      .oe_n_o    (ram_oe_n_o),
      .we_n_o    (ram_we_n_o),
      .dout_en_o (ram_dout_en_o)
   );

   // An abort in the last IF cycle still suppresses if_done.
   assign if_done_s  = last_s && (owner_q == OWN_IF) && !if_abort_i;
   assign mem_done_s = last_s && (owner_q == OWN_MEM);

   assign if_done_o   = if_done_s;
   assign mem_done_o  = mem_done_s;
   assign if_rdata_o  = if_done_s  ? ram_din_i : {DATA_W{1'b0}};
   assign mem_rdata_o = mem_done_s ? ram_din_i : {DATA_W{1'b0}};
   assign stall_o     = (if_req_i && !if_done_s && !if_abort_i) || (mem_req_i && !mem_done_s);
   assign ram_addr_o  = ram_addr_q;
   assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: instance a uses ACCESS_CYCLES=2, instance b uses 3.
module tb_sram_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        if_req, if_abort, if_done, mem_req, mem_we, mem_done, stall;
   logic        ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n;
   logic [15:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, ram_dout, ram_din;
   logic [17:0] ram_addr;

   logic        b_if_req, b_if_abort, b_if_done, b_mem_req, b_mem_we, b_mem_done, b_stall;
   logic        b_ram_dout_en, b_ram_ce_n, b_ram_oe_n, b_ram_we_n;
   logic [15:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata, b_ram_dout, b_ram_din;
   logic [17:0] b_ram_addr;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   sram_arbiter #(.ACCESS_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_abort_i(if_abort),
      .if_rdata_o(if_rdata), .if_done_o(if_done),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_rdata_o(mem_rdata), .mem_done_o(mem_done), .stall_o(stall),
      .ram_addr_o(ram_addr), .ram_dout_o(ram_dout), .ram_dout_en_o(ram_dout_en),
      .ram_din_i(ram_din), .ram_ce_n_o(ram_ce_n), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n)
   );

   sram_arbiter #(.ACCESS_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst),
      .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_abort_i(b_if_abort),
      .if_rdata_o(b_if_rdata), .if_done_o(b_if_done),
      .mem_req_i(b_mem_req), .mem_we_i(b_mem_we), .mem_addr_i(b_mem_addr), .mem_wdata_i(b_mem_wdata),
      .mem_rdata_o(b_mem_rdata), .mem_done_o(b_mem_done), .stall_o(b_stall),
      .ram_addr_o(b_ram_addr), .ram_dout_o(b_ram_dout), .ram_dout_en_o(b_ram_dout_en),
      .ram_din_i(b_ram_din), .ram_ce_n_o(b_ram_ce_n), .ram_oe_n_o(b_ram_oe_n), .ram_we_n_o(b_ram_we_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Strobes of instance a, expected {ce_n, oe_n, we_n, dout_en}.
   task automatic chk_strb(input string tag, input logic [3:0] exp);
      chk(tag, 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dout_en}), 32'(exp));
   endtask

   initial begin
      int k;
      rst = 1'b1;
      if_req = 1'b0; if_abort = 1'b0; if_addr = 16'h0000;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000; ram_din = 16'h0000;
      b_if_req = 1'b0; b_if_abort = 1'b0; b_if_addr = 16'h0000;
      b_mem_req = 1'b0; b_mem_we = 1'b0; b_mem_addr = 16'h0000; b_mem_wdata = 16'h0000; b_ram_din = 16'h0000;

      // Reset state
      @(negedge clk);
      chk_strb("rst_strobes", 4'b1110);
      chk("rst_addr", 32'(ram_addr), 32'h0);
      chk("rst_dout", 32'(ram_dout), 32'h0);
      chk("rst_done", 32'({if_done, mem_done, stall}), 32'h0);
      chk("rst_rdata", 32'({if_rdata, mem_rdata}), 32'h0);
      rst = 1'b0;

      // 1. Single IF read
      @(negedge clk);
      if_addr = 16'h0010; ram_din = 16'h1234; if_req = 1'b1; exp_q.push_back(16'h1234);
      #1 chk("t1_stall_req", 32'(stall), 32'h1);
      @(negedge clk);
      chk("t1_addr", 32'(ram_addr), 32'h00010);
      chk_strb("t1_strb_b1", 4'b0010);
      chk("t1_done_b1", 32'({if_done, stall}), 32'b01);
      @(negedge clk);
      chk_strb("t1_strb_b2", 4'b0010);
      chk("t1_done_b2", 32'({if_done, stall}), 32'b10);
      chk("t1_rdata", 32'(if_rdata), 32'(exp_q.pop_front()));
      if_req = 1'b0;
      @(negedge clk);
      chk_strb("t1_strb_idle", 4'b1110);
      chk("t1_idle_done", 32'({if_done, if_rdata}), 32'h0);

      // 2. IF and MEM read raised together: MEM first
      if_req = 1'b1; if_addr = 16'h0044;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0200; ram_din = 16'hA5A5;
      exp_q.push_back(16'hA5A5);
      @(negedge clk);
      chk("t2_addr_mem", 32'(ram_addr), 32'h00200);
      chk("t2_c2_done", 32'({if_done, mem_done}), 32'h0);
      chk_strb("t2_c2_strb", 4'b0010);
      @(negedge clk);
      chk("t2_c3_done", 32'({if_done, mem_done}), 32'b01);
      chk("t2_mem_rdata", 32'(mem_rdata), 32'(exp_q.pop_front()));
      mem_req = 1'b0; ram_din = 16'h5A5A; exp_q.push_back(16'h5A5A);
      @(negedge clk);
      chk_strb("t2_c4_gap", 4'b1110);
      chk("t2_c4_stall", 32'({if_done, mem_done, stall}), 32'b001);
      @(negedge clk);
      chk("t2_addr_if", 32'(ram_addr), 32'h00044);
      chk("t2_c5_done", 32'(if_done), 32'h0);
      @(negedge clk);
      chk("t2_c6_done", 32'({if_done, mem_done}), 32'b10);
      chk("t2_if_rdata", 32'(if_rdata), 32'(exp_q.pop_front()));
      if_req = 1'b0;
      @(negedge clk);

      // 3. MEM write 0xBEEF to 0x8000
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'hBEEF;
      @(negedge clk);
      mem_wdata = 16'h0BAD; mem_addr = 16'h0001;
      chk("t3_addr", 32'(ram_addr), 32'h08000);
      chk_strb("t3_strb_b1", 4'b0101);
      chk("t3_dout_b1", 32'(ram_dout), 32'hBEEF);
      chk("t3_done_b1", 32'(mem_done), 32'h0);
      @(negedge clk);
      chk_strb("t3_strb_b2", 4'b0111);
      chk("t3_dout_b2", 32'(ram_dout), 32'hBEEF);
      chk("t3_done_b2", 32'(mem_done), 32'h1);
      mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      chk_strb("t3_strb_idle", 4'b1110);

      // 4. IF abort in first BUSY cycle with MEM pending
      if_req = 1'b1; if_addr = 16'h0020;
      @(negedge clk);
      chk("t4_if_busy", 32'({ram_ce_n, if_done}), 32'h0);
      if_abort = 1'b1; mem_req = 1'b1; mem_addr = 16'h0300; ram_din = 16'h7777;
      exp_q.push_back(16'h7777);
      #1 chk("t4_stall_abort", 32'({if_done, stall}), 32'b01);
      @(negedge clk);
      chk_strb("t4_idle_strb", 4'b1110);
      chk("t4_no_if_done", 32'(if_done), 32'h0);
      if_abort = 1'b0; if_req = 1'b0;
      @(negedge clk);
      chk("t4_mem_addr", 32'(ram_addr), 32'h00300);
      chk_strb("t4_mem_strb", 4'b0010);
      @(negedge clk);
      chk("t4_mem_done", 32'({if_done, mem_done}), 32'b01);
      chk("t4_mem_rdata", 32'(mem_rdata), 32'(exp_q.pop_front()));
      mem_req = 1'b0;
      @(negedge clk);

      // 5. Reset pulsed mid-write
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0400; mem_wdata = 16'h1111;
      @(negedge clk);
      chk_strb("t5_pre_rst", 4'b0101);
      #2 rst = 1'b1;
      #1 chk_strb("t5_rst_strb", 4'b1110);
      chk("t5_rst_done", 32'(mem_done), 32'h0);
      @(negedge clk);
      chk("t5_rst_hold", 32'({mem_done, ram_ce_n}), 32'b01);
      mem_addr = 16'h0500; mem_wdata = 16'h2222; rst = 1'b0;
      @(negedge clk);
      chk("t5_new_addr", 32'(ram_addr), 32'h00500);
      chk("t5_new_dout", 32'(ram_dout), 32'h2222);
      chk_strb("t5_new_strb", 4'b0101);
      @(negedge clk);
      chk("t5_new_done", 32'(mem_done), 32'h1);
      chk_strb("t5_new_hold", 4'b0111);
      mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);

      // 7. Abort arriving in the last IF cycle suppresses if_done
      if_req = 1'b1; if_addr = 16'h0030; ram_din = 16'h9999;
      @(negedge clk);
      @(negedge clk);
      chk("t7_done_pre", 32'(if_done), 32'h1);
      if_abort = 1'b1;
      #1 chk("t7_done_abort", 32'({if_done, if_rdata}), 32'h0);
      @(negedge clk);
      if_abort = 1'b0; if_req = 1'b0;
      chk_strb("t7_idle", 4'b1110);

      // 6. ACCESS_CYCLES=3, four back-to-back MEM reads
      b_mem_req = 1'b1; b_mem_we = 1'b0;
      b_mem_addr = 16'h1000; b_ram_din = 16'hC000; exp_q.push_back(16'hC000);
      for (int i = 0; i < 4; i++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!b_mem_done && k < 10);
         chk("t6_latency", 32'(k), (i == 0) ? 32'd3 : 32'd4);
         chk("t6_addr", 32'(b_ram_addr), 32'(18'h01000 + 18'(i)));
         chk("t6_rdata", 32'(b_mem_rdata), 32'(exp_q.pop_front()));
         b_mem_addr = 16'h1000 + 16'(i + 1);
         b_ram_din  = 16'hC000 + 16'((i + 1) * 16'h0111);
         exp_q.push_back(b_ram_din);
      end
      b_mem_req = 1'b0;
      void'(exp_q.pop_front());
      @(negedge clk);
      chk("t6_idle", 32'({b_mem_done, b_ram_ce_n}), 32'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
